// File: rtl/mem_port_arbiter.sv
// Shares one Ram port between instruction fetch (IF) and load/store (LS), round-robin on ties.
// Optional misaligned-address trap: define MEM_ARB_ALIGN_CHECK_EN to add if_err / ls_err.
//
// state  | meaning
// -------+----------------------------------------------------------------
// S_IDLE | sample requests, pick a winner, latch its access
// S_BUSY | Ram access in flight for MEM_LAT cycles; gnt/write strobe in first cycle
// S_RESP | winner's valid pulse; a stale req is never re-accepted here
module mem_port_arbiter #(
  parameter int MEM_LAT = 1,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [31:0]       if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [31:0]       ls_wdata,
  output logic              ls_gnt,
  output logic              ls_valid,
  output logic [31:0]       ls_rdata,
`ifdef MEM_ARB_ALIGN_CHECK_EN
  output logic              if_err,
  output logic              ls_err,
`endif
  output logic              write_enable,
  output logic [ADDR_W-1:0] mem_addr_bus,
  output logic [31:0]       bus_to_mem_32,
  input  logic [31:0]       bus_from_mem_32
);

  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              take, busy_last;

  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              we_q;
  logic              win_ls_q;
  logic              last_ls_q;

  logic              pick_ls;
  logic [ADDR_W-1:0] sel_addr;

  // LS wins when alone, or on a tie when IF was served last
  assign pick_ls  = ls_req & (~if_req | ~last_ls_q);
  assign sel_addr = pick_ls ? ls_addr : if_addr;

`ifdef MEM_ARB_ALIGN_CHECK_EN
  logic sel_mis;
  logic mis_q;
  assign sel_mis = (sel_addr[1:0] != 2'b00);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Busy timer counts down from MEM_LAT-1; terminal count at zero
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    take      = 1'b0;
    busy_last = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (if_req | ls_req) begin
          take    = 1'b1;
          cnt_d   = CNT_W'(MEM_LAT - 1);
          state_d = S_BUSY;
`ifdef MEM_ARB_ALIGN_CHECK_EN
          if (sel_mis) state_d = S_RESP;
`endif
        end
      end
      S_BUSY: begin
        if (cnt_q == '0) begin
          busy_last = 1'b1;
          state_d   = S_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      win_ls_q     <= 1'b0;
      last_ls_q    <= 1'b1;
      if_gnt       <= 1'b0;
      ls_gnt       <= 1'b0;
      if_valid     <= 1'b0;
      ls_valid     <= 1'b0;
      write_enable <= 1'b0;
      if_rdata     <= '0;
      ls_rdata     <= '0;
`ifdef MEM_ARB_ALIGN_CHECK_EN
      if_err       <= 1'b0;
      ls_err       <= 1'b0;
      mis_q        <= 1'b0;
`endif
    end else begin
      if_gnt       <= 1'b0;
      ls_gnt       <= 1'b0;
      if_valid     <= 1'b0;
      ls_valid     <= 1'b0;
      write_enable <= 1'b0;
`ifdef MEM_ARB_ALIGN_CHECK_EN
      if_err       <= 1'b0;
      ls_err       <= 1'b0;
`endif
      if (take) begin
        addr_q    <= sel_addr;
        wdata_q   <= pick_ls ? ls_wdata : 32'h0;
        we_q      <= pick_ls & ls_we;
        win_ls_q  <= pick_ls;
        last_ls_q <= pick_ls;
        if_gnt    <= ~pick_ls;
        ls_gnt    <= pick_ls;
`ifdef MEM_ARB_ALIGN_CHECK_EN
        write_enable <= pick_ls & ls_we & ~sel_mis;
        mis_q        <= sel_mis;
`else
        write_enable <= pick_ls & ls_we;
`endif
      end
      if (busy_last) begin
        if_valid <= ~win_ls_q;
        ls_valid <= win_ls_q;
        if (!we_q) begin
          if (win_ls_q) ls_rdata <= bus_from_mem_32;
          else          if_rdata <= bus_from_mem_32;
        end
      end
`ifdef MEM_ARB_ALIGN_CHECK_EN
      // Trapped access: gnt shows during RESP, valid/err follow one cycle later
      if (state_q == S_RESP && mis_q) begin
        mis_q    <= 1'b0;
        if_valid <= ~win_ls_q;
        ls_valid <= win_ls_q;
        if_err   <= ~win_ls_q;
        ls_err   <= win_ls_q;
        if (win_ls_q) ls_rdata <= '0;
        else          if_rdata <= '0;
      end
`endif
    end
  end

  assign mem_addr_bus  = (state_q == S_BUSY) ? addr_q  : '0;
  assign bus_to_mem_32 = (state_q == S_BUSY) ? wdata_q : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at MEM_LAT=1, one at MEM_LAT=3, shared Ram model.
module tb_mem_port_arbiter;

`ifdef MEM_ARB_ALIGN_CHECK_EN
  localparam logic [31:0] A_IF = 32'h0000_0100;
  localparam logic [31:0] A_LS = 32'h0000_0078;
`else
  localparam logic [31:0] A_IF = 32'h0000_00FF;
  localparam logic [31:0] A_LS = 32'h0000_0079;
`endif
  localparam logic [31:0] A3_RD = 32'h0000_0040;
  localparam logic [31:0] A3_LD = 32'h0000_0080;

  logic clk = 1'b0;
  logic rst;

  logic        if_req, ls_req, ls_we;
  logic [31:0] if_addr, ls_addr, ls_wdata;
  logic        if_gnt, if_valid, ls_gnt, ls_valid, write_enable;
  logic [31:0] if_rdata, ls_rdata, mem_addr_bus, bus_to_mem_32, bus_from_mem_32;

  logic        if_req_3, ls_req_3, ls_we_3;
  logic [31:0] if_addr_3, ls_addr_3, ls_wdata_3;
  logic        if_gnt_3, if_valid_3, ls_gnt_3, ls_valid_3, write_enable_3;
  logic [31:0] if_rdata_3, ls_rdata_3, mem_addr_bus_3, bus_to_mem_32_3, bus_from_mem_32_3;

`ifdef MEM_ARB_ALIGN_CHECK_EN
  logic if_err, ls_err, if_err_3, ls_err_3;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] ram [256];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) ram[i] <= 32'h0;
      ram[A_IF[7:0]]  <= 32'h07B0_0293;
      ram[A3_RD[7:0]] <= 32'hCAFE_0004;
      ram[A3_LD[7:0]] <= 32'h1234_5678;
    end else if (write_enable) begin
      ram[mem_addr_bus[7:0]] <= bus_to_mem_32;
    end
  end

  assign bus_from_mem_32   = ram[mem_addr_bus[7:0]];
  assign bus_from_mem_32_3 = ram[mem_addr_bus_3[7:0]];

  mem_port_arbiter #(.MEM_LAT(1), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_valid(ls_valid), .ls_rdata(ls_rdata),
`ifdef MEM_ARB_ALIGN_CHECK_EN
    .if_err(if_err), .ls_err(ls_err),
`endif
    .write_enable(write_enable), .mem_addr_bus(mem_addr_bus),
    .bus_to_mem_32(bus_to_mem_32), .bus_from_mem_32(bus_from_mem_32)
  );

  mem_port_arbiter #(.MEM_LAT(3), .ADDR_W(32)) dut3 (
    .clk(clk), .rst(rst),
    .if_req(if_req_3), .if_addr(if_addr_3), .if_gnt(if_gnt_3), .if_valid(if_valid_3), .if_rdata(if_rdata_3),
    .ls_req(ls_req_3), .ls_we(ls_we_3), .ls_addr(ls_addr_3), .ls_wdata(ls_wdata_3),
    .ls_gnt(ls_gnt_3), .ls_valid(ls_valid_3), .ls_rdata(ls_rdata_3),
`ifdef MEM_ARB_ALIGN_CHECK_EN
    .if_err(if_err_3), .ls_err(ls_err_3),
`endif
    .write_enable(write_enable_3), .mem_addr_bus(mem_addr_bus_3),
    .bus_to_mem_32(bus_to_mem_32_3), .bus_from_mem_32(bus_from_mem_32_3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0;
    if_req_3 = 1'b0; if_addr_3 = '0;
    ls_req_3 = 1'b0; ls_we_3 = 1'b0; ls_addr_3 = '0; ls_wdata_3 = '0;
    tick(); tick();

    chk("rst_gnts",   {30'h0, if_gnt, ls_gnt}, 32'h0);
    chk("rst_valids", {30'h0, if_valid, ls_valid}, 32'h0);
    chk("rst_we",     {31'h0, write_enable}, 32'h0);
    chk("rst_addr",   mem_addr_bus, 32'h0);
    chk("rst_wdata",  bus_to_mem_32, 32'h0);
    chk("rst_rdata",  if_rdata | ls_rdata, 32'h0);
    rst = 1'b0;
    tick();

    // IF-only fetch, MEM_LAT=1
    if_addr = A_IF; if_req = 1'b1;
    tick();
    chk("f_if_gnt", {31'h0, if_gnt}, 32'h1);
    chk("f_ls_gnt", {31'h0, ls_gnt}, 32'h0);
    chk("f_addr",   mem_addr_bus, A_IF);
    chk("f_we",     {31'h0, write_enable}, 32'h0);
    if_req = 1'b0;
    tick();
    chk("f_valid",  {31'h0, if_valid}, 32'h1);
    chk("f_rdata",  if_rdata, 32'h07B0_0293);
    chk("f_addr_resp", mem_addr_bus, 32'h0);
    chk("f_we_resp", {31'h0, write_enable}, 32'h0);
    tick();
    chk("f_valid_pulse", {31'h0, if_valid}, 32'h0);

    // LS store then load back
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = A_LS; ls_wdata = 32'h58;
    tick();
    chk("st_gnt",   {31'h0, ls_gnt}, 32'h1);
    chk("st_we",    {31'h0, write_enable}, 32'h1);
    chk("st_wdata", bus_to_mem_32, 32'h58);
    chk("st_addr",  mem_addr_bus, A_LS);
    ls_req = 1'b0;
    tick();
    chk("st_we_off", {31'h0, write_enable}, 32'h0);
    chk("st_valid",  {31'h0, ls_valid}, 32'h1);
    chk("st_rdata",  ls_rdata, 32'h0);
    tick();
    ls_req = 1'b1; ls_we = 1'b0;
    tick();
    chk("ld_gnt", {31'h0, ls_gnt}, 32'h1);
    chk("ld_we",  {31'h0, write_enable}, 32'h0);
    ls_req = 1'b0;
    tick();
    chk("ld_valid", {31'h0, ls_valid}, 32'h1);
    chk("ld_rdata", ls_rdata, 32'h58);
    tick();

    // Round-robin: tie after reset goes to IF, IF re-requests so next tie goes to LS
    rst = 1'b1; tick(); rst = 1'b0;
    if_addr = A_IF; if_req = 1'b1;
    ls_addr = A_LS; ls_we = 1'b0; ls_req = 1'b1;
    tick();
    chk("rr1_if_gnt", {31'h0, if_gnt}, 32'h1);
    chk("rr1_ls_gnt", {31'h0, ls_gnt}, 32'h0);
    tick();
    chk("rr1_if_valid", {31'h0, if_valid}, 32'h1);
    tick();
    chk("rr_idle_gnts", {30'h0, if_gnt, ls_gnt}, 32'h0);
    tick();
    chk("rr2_ls_gnt", {31'h0, ls_gnt}, 32'h1);
    chk("rr2_if_gnt", {31'h0, if_gnt}, 32'h0);
    ls_req = 1'b0;
    tick();
    chk("rr2_ls_valid", {30'h0, if_valid, ls_valid}, 32'h1);
    tick();
    tick();
    chk("rr3_if_gnt", {30'h0, if_gnt, ls_gnt}, 32'h2);
    if_req = 1'b0;
    tick(); tick();

    // MEM_LAT=3: gnt c1, valid c4, request raised in BUSY granted from the c5 IDLE
    if_addr_3 = A3_RD; if_req_3 = 1'b1;
    tick();
    chk("l3_gnt_c1",  {31'h0, if_gnt_3}, 32'h1);
    chk("l3_addr_c1", mem_addr_bus_3, A3_RD);
    if_req_3 = 1'b0;
    tick();
    chk("l3_gnt_c2", {31'h0, if_gnt_3}, 32'h0);
    ls_addr_3 = A3_LD; ls_req_3 = 1'b1;
    tick();
    chk("l3_c3", {30'h0, if_valid_3, ls_gnt_3}, 32'h0);
    tick();
    chk("l3_valid_c4", {31'h0, if_valid_3}, 32'h1);
    chk("l3_rdata_c4", if_rdata_3, 32'hCAFE_0004);
    chk("l3_ls_gnt_c4", {31'h0, ls_gnt_3}, 32'h0);
    tick();
    chk("l3_ls_gnt_c5", {31'h0, ls_gnt_3}, 32'h0);
    tick();
    chk("l3_ls_gnt_c6", {31'h0, ls_gnt_3}, 32'h1);
    ls_req_3 = 1'b0;
    tick(); tick(); tick();
    chk("l3_ls_valid", {31'h0, ls_valid_3}, 32'h1);
    chk("l3_ls_rdata", ls_rdata_3, 32'h1234_5678);
    tick();

    // Reset in the second BUSY cycle of a read
    if_addr_3 = A3_RD; if_req_3 = 1'b1;
    tick();
    if_req_3 = 1'b0;
    tick();
    chk("rb_addr_busy", mem_addr_bus_3, A3_RD);
    rst = 1'b1;
    #1;
    chk("rb_addr", mem_addr_bus_3, 32'h0);
    chk("rb_rdata", if_rdata_3 | ls_rdata_3, 32'h0);
    chk("rb_flags", {28'h0, if_gnt_3, ls_gnt_3, if_valid_3, ls_valid_3}, 32'h0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rb_no_valid", {30'h0, if_valid_3, ls_valid_3}, 32'h0);
    end
    if_req_3 = 1'b1;
    tick();
    chk("ra_gnt", {31'h0, if_gnt_3}, 32'h1);
    if_req_3 = 1'b0;
    tick(); tick(); tick();
    chk("ra_valid", {31'h0, if_valid_3}, 32'h1);
    chk("ra_rdata", if_rdata_3, 32'hCAFE_0004);
    tick();

`ifdef MEM_ARB_ALIGN_CHECK_EN
    // Misaligned store is granted but trapped: no Ram traffic, valid+err next cycle
    ls_addr = 32'h7A; ls_we = 1'b1; ls_wdata = 32'h99; ls_req = 1'b1;
    tick();
    chk("al_gnt",  {31'h0, ls_gnt}, 32'h1);
    chk("al_we",   {31'h0, write_enable}, 32'h0);
    chk("al_addr", mem_addr_bus, 32'h0);
    ls_req = 1'b0;
    tick();
    chk("al_valid_err", {30'h0, ls_valid, ls_err}, 32'h3);
    chk("al_rdata", ls_rdata, 32'h0);
    chk("al_we2",   {31'h0, write_enable}, 32'h0);
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
